regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter LANES, default 16, vector lanes per register (wd3 width).
REQ-002 SHALL have parameter DW, default 32, bits per lane.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have ports alu_valid/mem_valid, input, 1 each, writeback request pending.
REQ-006 SHALL have ports alu_ready/mem_ready, output, 1 each, request accepted this cycle.
REQ-007 SHALL have ports alu_vs/mem_vs, input, 1 each, destination select: 0=scalar, 1=vector.
REQ-008 SHALL have ports alu_cmd/mem_cmd, input, 3 each, register-file write command.
REQ-009 SHALL have ports alu_rd/mem_rd, input, 4 each, destination register index.
REQ-010 SHALL have ports alu_data/mem_data, input, LANES x DW each, write data; lane LANES-1 carries scalar data.
REQ-011 SHALL have ports we3 (1), ra3 (4), wd3 (LANES x DW), selec_v_s_w (1) and cmd (3), all outputs, registered register-file write port.
REQ-012 SHALL have port drop, output, 1, one-cycle pulse when an illegal write is discarded.

Function
REQ-013 SHALL accept request X in cycle N when X_valid=1 and X_ready=1 (same-cycle combinational ready).
REQ-014 SHALL assert at most one ready per cycle; ready=1 only with the matching valid=1.
REQ-015 SHALL, with a single valid requester, grant that requester immediately.
REQ-016 SHALL, with both valid, grant the requester named by a 1-bit round-robin pointer; pointer SHALL move to the other requester after every contested grant and stay unchanged otherwise.
REQ-017 SHALL drive the accepted request on the write port in cycle N+1: we3=1, ra3=rd, wd3=data, selec_v_s_w=vs, cmd=cmd; with no acceptance, we3=0 and the other outputs hold their previous values.
REQ-018 SHALL classify an access as scalar when vs=0 or when (vs=1 and cmd=3'b101).
REQ-019 SHALL treat a scalar access with rd=4'hF (PC alias, not writable) as illegal: accept it, keep we3=0 in N+1, and pulse drop=1 in N+1.
REQ-020 SHALL keep a requester's sampled inputs stable while valid=1 and ready=0; violations are not checked.
REQ-021 SHALL sustain one write per cycle under back-to-back requests (no bubbles).

Reset
REQ-022 SHALL, while rst=1 at posedge, clear we3, drop, ra3, wd3, selec_v_s_w and cmd to 0 and set pointer to ALU.
REQ-023 SHALL force alu_ready=mem_ready=0 while rst=1; requests present during reset are not accepted.
REQ-024 SHALL discard a write registered in the cycle before reset asserts (we3=0 the cycle after rst).

Configuration
REQ-025 SHALL, when WB_PERF_EN is defined, add outputs conflict_cnt (16) and drop_cnt (16): saturating counters of contested cycles and illegal drops, cleared by rst.
REQ-026 SHALL, without WB_PERF_EN, omit both ports and counters; all other behaviour identical.

Structure
REQ-027 SHALL place wb_req_t (vs, cmd, rd, data), CMD_SCALAR_FROM_VEC=3'b101 and REG_PC=4'hF in shared package wb_pkg.
REQ-028 SHALL implement arbitration in sub-module rr_arb2 (two-requester round-robin, pointer state inside).

Verification
REQ-029 SHALL cover single ALU vector write rd=3, data lanes=lane index -> alu_ready same cycle; next cycle we3=1, ra3=3, selec_v_s_w=1, wd3[5]=5.
REQ-030 SHALL cover both valid for 4 cycles after reset -> grants ALU, MEM, ALU, MEM; 4 consecutive we3=1 cycles; conflict_cnt=4 when WB_PERF_EN.
REQ-031 SHALL cover MEM scalar write rd=4'hF, vs=0 -> mem_ready=1; next cycle we3=0, drop=1; same with vs=1, cmd=3'b101 -> drop=1; vs=1, cmd=3'b000, rd=4'hF -> we3=1.
REQ-032 SHALL cover rst asserted for one cycle while both valid -> no ready that cycle, we3=0 next cycle, pointer at ALU afterwards.
REQ-033 SHALL cover 70000 contested cycles with WB_PERF_EN -> conflict_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared writeback request type and register-file constants
package wb_pkg;
   localparam logic [2:0] CMD_SCALAR_FROM_VEC = 3'b101;
   localparam logic [3:0] REG_PC = 4'hF;
   localparam int WB_DATA_MAX = 512;
   typedef struct packed {
      logic                   vs;
      logic [2:0]             cmd;
      logic [3:0]             rd;
      logic [WB_DATA_MAX-1:0] data;
   } wb_req_t;
   function automatic logic is_illegal(input wb_req_t r);
      return (!r.vs || r.cmd == CMD_SCALAR_FROM_VEC) && r.rd == REG_PC;
   endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter; ptr=0 favours requester a
module rr_arb2 (
   input  logic clk,
   input  logic rst,
   input  logic req_a,
   input  logic req_b,
   output logic gnt_a,
   output logic gnt_b,
   output logic contested
);
   logic ptr;
   // grant the lone requester, or the pointed-to one when both ask; nothing during reset
   always_comb begin
      contested = req_a & req_b;
      gnt_a = !rst & req_a & (!req_b | !ptr);
      gnt_b = !rst & req_b & (!req_a | ptr);
   end
   // pointer flips only after a contested grant
   always_ff @(posedge clk) begin
      if (rst) ptr <= 1'b0;
      else if (contested) ptr <= ~ptr;
   end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges ALU/MEM writebacks onto one registered RF write port (WB_PERF_EN adds perf counters)
module regfile_wb_arbiter
   import wb_pkg::*;
#(
   parameter int LANES = 16,
   parameter int DW = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                alu_valid,
   input  logic                mem_valid,
   output logic                alu_ready,
   output logic                mem_ready,
   input  logic                alu_vs,
   input  logic                mem_vs,
   input  logic [2:0]          alu_cmd,
   input  logic [2:0]          mem_cmd,
   input  logic [3:0]          alu_rd,
   input  logic [3:0]          mem_rd,
   input  logic [LANES*DW-1:0] alu_data,
   input  logic [LANES*DW-1:0] mem_data,
   output logic                we3,
   output logic [3:0]          ra3,
   output logic [LANES*DW-1:0] wd3,
   output logic                selec_v_s_w,
   output logic [2:0]          cmd,
   output logic                drop
`ifdef WB_PERF_EN
   ,
   output logic [15:0]         conflict_cnt,
   output logic [15:0]         drop_cnt
`endif
);
   wb_req_t alu_req, mem_req, sel;
   logic accept, illegal, contested;
   rr_arb2 u_arb (
      .clk(clk),
      .rst(rst),
      .req_a(alu_valid),
      .req_b(mem_valid),
      .gnt_a(alu_ready),
      .gnt_b(mem_ready),
      .contested(contested)
   );
   // pick the granted request and classify writes to the PC alias as illegal
   always_comb begin
      alu_req = '{vs: alu_vs, cmd: alu_cmd, rd: alu_rd, data: WB_DATA_MAX'(alu_data)};
      mem_req = '{vs: mem_vs, cmd: mem_cmd, rd: mem_rd, data: WB_DATA_MAX'(mem_data)};
      sel = alu_ready ? alu_req : mem_req;
      accept = alu_ready | mem_ready;
      illegal = is_illegal(sel);
   end
   // register the write port; fields only move on a legal write
   always_ff @(posedge clk) begin
      if (rst) begin
         we3 <= 1'b0;
         drop <= 1'b0;
         ra3 <= '0;
         wd3 <= '0;
         selec_v_s_w <= 1'b0;
         cmd <= '0;
      end else begin
         we3 <= accept & !illegal;
         drop <= accept & illegal;
         if (accept & !illegal) begin
            ra3 <= sel.rd;
            wd3 <= sel.data[LANES*DW-1:0];
            selec_v_s_w <= sel.vs;
            cmd <= sel.cmd;
         end
      end
   end
`ifdef WB_PERF_EN
   // saturating counts of contested cycles and discarded illegal writes
   always_ff @(posedge clk) begin
      if (rst) begin
         conflict_cnt <= '0;
         drop_cnt <= '0;
      end else begin
         if (contested && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
         if (accept && illegal && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: table vectors, corner sequences and randomized checks against a reference model
module tb_regfile_wb_arbiter;
   logic clk, rst;
   logic av, mv, ar, mr, avs, mvs;
   logic [2:0] acmd, mcmd, cmd;
   logic [3:0] ard, mrd, ra3;
   logic [511:0] adata, mdata, wd3;
   logic we3, selec, drop;
`ifdef WB_PERF_EN
   logic [15:0] conflict_cnt, drop_cnt;
`endif
   int n_tests, n_fail;
   logic m_ptr, m_we, m_drop, m_vs;
   logic [3:0] m_ra;
   logic [2:0] m_cmd;
   logic [511:0] m_wd;
   int m_conf, m_dropc;
   logic s_ar, s_mr;

   regfile_wb_arbiter dut (
      .clk(clk), .rst(rst),
      .alu_valid(av), .mem_valid(mv), .alu_ready(ar), .mem_ready(mr),
      .alu_vs(avs), .mem_vs(mvs), .alu_cmd(acmd), .mem_cmd(mcmd),
      .alu_rd(ard), .mem_rd(mrd), .alu_data(adata), .mem_data(mdata),
      .we3(we3), .ra3(ra3), .wd3(wd3), .selec_v_s_w(selec), .cmd(cmd), .drop(drop)
`ifdef WB_PERF_EN
      , .conflict_cnt(conflict_cnt), .drop_cnt(drop_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [511:0] mk_data(input int seed);
      logic [511:0] d;
      for (int i = 0; i < 16; i++) d[i*32 +: 32] = 32'(seed + i);
      return d;
   endfunction

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // one clock: check readies, advance model at the edge, check registered outputs
   task automatic cycle();
      logic ga, gm, acc, ill, vs;
      logic [2:0] c;
      logic [3:0] r;
      logic [511:0] d;
      #1;
      ga = !rst && av && (!mv || !m_ptr);
      gm = !rst && mv && (!av || m_ptr);
      s_ar = ar;
      s_mr = mr;
      chk("alu_ready", 512'(ar), 512'(ga));
      chk("mem_ready", 512'(mr), 512'(gm));
      acc = ga || gm;
      vs = ga ? avs : mvs;
      c = ga ? acmd : mcmd;
      r = ga ? ard : mrd;
      d = ga ? adata : mdata;
      ill = (!vs || c == 3'b101) && r == 4'hF;
      @(posedge clk);
      if (rst) begin
         m_we = 0; m_drop = 0; m_ra = 0; m_wd = 0; m_vs = 0; m_cmd = 0; m_ptr = 0;
         m_conf = 0; m_dropc = 0;
      end else begin
         m_we = acc && !ill;
         m_drop = acc && ill;
         if (m_we) begin m_ra = r; m_wd = d; m_vs = vs; m_cmd = c; end
         if (av && mv) begin
            m_ptr = !m_ptr;
            if (m_conf < 65535) m_conf++;
         end
         if (m_drop && m_dropc < 65535) m_dropc++;
      end
      #1;
      chk("we3", 512'(we3), 512'(m_we));
      chk("drop", 512'(drop), 512'(m_drop));
      chk("ra3", 512'(ra3), 512'(m_ra));
      chk("wd3", wd3, m_wd);
      chk("selec_v_s_w", 512'(selec), 512'(m_vs));
      chk("cmd", 512'(cmd), 512'(m_cmd));
`ifdef WB_PERF_EN
      chk("conflict_cnt", 512'(conflict_cnt), 512'(m_conf));
      chk("drop_cnt", 512'(drop_cnt), 512'(m_dropc));
`endif
      @(negedge clk);
   endtask

   typedef struct {
      int av, mv, avs, mvs, acmd, mcmd, ard, mrd, aseed, mseed;
      int ear, emr, ewe, edrop, era, evs, ecmd, eseed;
   } vec_t;
   vec_t tbl [11];

   initial begin
      n_tests = 0; n_fail = 0;
      m_ptr = 0; m_we = 0; m_drop = 0; m_ra = 0; m_wd = 0; m_vs = 0; m_cmd = 0;
      m_conf = 0; m_dropc = 0;
      tbl[0]  = '{1,0,1,0,0,0,3,0,  0,200, 1,0,1,0,  3,1,0,  0};
      tbl[1]  = '{0,1,0,0,0,0,0,15, 101,201, 0,1,0,1,  3,1,0,  0};
      tbl[2]  = '{0,1,0,1,0,5,0,15, 102,202, 0,1,0,1,  3,1,0,  0};
      tbl[3]  = '{0,1,0,1,0,0,0,15, 103,203, 0,1,1,0, 15,1,0,203};
      tbl[4]  = '{1,1,1,1,2,3,1,2,  104,204, 1,0,1,0,  1,1,2,104};
      tbl[5]  = '{1,1,1,0,2,3,1,2,  105,205, 0,1,1,0,  2,0,3,205};
      tbl[6]  = '{0,0,1,1,0,0,0,0,  106,206, 0,0,0,0,  2,0,3,205};
      tbl[7]  = '{1,0,0,0,4,0,4,0,  107,207, 1,0,1,0,  4,0,4,107};
      tbl[8]  = '{1,0,0,0,1,0,15,0, 108,208, 1,0,0,1,  4,0,4,107};
      tbl[9]  = '{1,1,0,1,1,6,15,5, 109,209, 1,0,0,1,  4,0,4,107};
      tbl[10] = '{1,1,1,1,7,6,6,7,  110,210, 0,1,1,0,  7,1,6,210};
      rst = 1; av = 0; mv = 0; avs = 0; mvs = 0; acmd = 0; mcmd = 0; ard = 0; mrd = 0;
      adata = '0; mdata = '0;
      @(negedge clk);
      cycle();
      chk("reset we3", 512'(we3), 512'(0));
      chk("reset wd3", wd3, 512'(0));
      rst = 0;
      foreach (tbl[k]) begin
         av = tbl[k].av[0]; mv = tbl[k].mv[0]; avs = tbl[k].avs[0]; mvs = tbl[k].mvs[0];
         acmd = tbl[k].acmd[2:0]; mcmd = tbl[k].mcmd[2:0];
         ard = tbl[k].ard[3:0]; mrd = tbl[k].mrd[3:0];
         adata = mk_data(tbl[k].aseed); mdata = mk_data(tbl[k].mseed);
         cycle();
         chk($sformatf("vec%0d alu_ready", k), 512'(s_ar), 512'(tbl[k].ear[0]));
         chk($sformatf("vec%0d mem_ready", k), 512'(s_mr), 512'(tbl[k].emr[0]));
         chk($sformatf("vec%0d we3", k), 512'(we3), 512'(tbl[k].ewe[0]));
         chk($sformatf("vec%0d drop", k), 512'(drop), 512'(tbl[k].edrop[0]));
         chk($sformatf("vec%0d ra3", k), 512'(ra3), 512'(tbl[k].era[3:0]));
         chk($sformatf("vec%0d vs", k), 512'(selec), 512'(tbl[k].evs[0]));
         chk($sformatf("vec%0d cmd", k), 512'(cmd), 512'(tbl[k].ecmd[2:0]));
         chk($sformatf("vec%0d wd3", k), wd3, mk_data(tbl[k].eseed));
         if (k == 0) chk("vec0 lane5", 512'(wd3[5*32 +: 32]), 512'(5));
      end
      // contested run straight after reset alternates ALU, MEM, ALU, MEM
      rst = 1; av = 1; mv = 1;
      cycle();
      rst = 0;
      for (int i = 0; i < 4; i++) begin
         ard = 4'(i); mrd = 4'(i + 8); avs = 1; mvs = 1; acmd = 0; mcmd = 0;
         cycle();
         chk($sformatf("rr%0d alu_ready", i), 512'(s_ar), 512'(i % 2 == 0));
         chk($sformatf("rr%0d we3", i), 512'(we3), 512'(1));
      end
`ifdef WB_PERF_EN
      chk("rr conflict_cnt", 512'(conflict_cnt), 512'(4));
`endif
      // one-cycle reset with both valid: no grant, no write, pointer back at ALU
      rst = 1;
      cycle();
      chk("rst ready", 512'({s_ar, s_mr}), 512'(0));
      chk("rst we3", 512'(we3), 512'(0));
      rst = 0;
      cycle();
      chk("post-rst alu first", 512'({s_ar, s_mr}), 512'(2'b10));
      // write accepted just before reset is discarded
      mv = 0;
      cycle();
      chk("pre-rst write we3", 512'(we3), 512'(1));
      rst = 1;
      cycle();
      chk("discard we3", 512'(we3), 512'(0));
      rst = 0;
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 29) == 0);
         av = 1'($urandom); mv = 1'($urandom); avs = 1'($urandom); mvs = 1'($urandom);
         acmd = ($urandom_range(0, 2) == 0) ? 3'b101 : 3'($urandom);
         mcmd = ($urandom_range(0, 2) == 0) ? 3'b101 : 3'($urandom);
         ard = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
         mrd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
         for (int j = 0; j < 16; j++) begin
            adata[j*32 +: 32] = $urandom;
            mdata[j*32 +: 32] = $urandom;
         end
         cycle();
      end
`ifdef WB_PERF_EN
      rst = 1; av = 1; mv = 1;
      @(negedge clk);
      rst = 0;
      repeat (70000) @(negedge clk);
      chk("conflict_cnt saturate", 512'(conflict_cnt), 512'(16'hFFFF));
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
